// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes and sequencer states.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between right-justified requester data and the 32-bit memory word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_dout,
    output logic [3:0]  lane_mask,
    output logic [31:0] store_data,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Stores replicate the payload into every lane; the lane mask picks the bytes that land.
    always_comb begin
        shifted    = mem_dout >> {offset, 3'b000};
        lane_mask  = 4'b0000;
        store_data = wdata;
        load_data  = 32'h0;
        case (size)
            SZ_BYTE: begin
                lane_mask  = 4'b0001 << offset;
                store_data = {4{wdata[7:0]}};
                load_data  = uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                lane_mask  = 4'b0011 << offset;
                store_data = {2{wdata[15:0]}};
                load_data  = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                lane_mask  = 4'b1111;
                store_data = wdata;
                load_data  = mem_dout;
            end
            default: begin
                lane_mask = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and IDLE->ISSUE->RESP sequencer sharing one data memory between two ports.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        wr,
    input  logic [1:0]        size0,
    input  logic [1:0]        size1,
    input  logic [1:0]        uns,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic [1:0]        ack,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    state_t      state;
    logic        last_gnt;
    logic        gnt;
    logic        lat_wr;
    logic        lat_uns;
    logic        lat_err;
    logic [1:0]  lat_size;
    logic [1:0]  lat_off;

    logic        win;
    logic        sel_wr;
    logic        sel_uns;
    logic        sel_err;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    logic [1:0]  al_size;
    logic        al_uns;
    logic [1:0]  al_off;
    logic [3:0]  lane_mask;
    logic [31:0] store_data;
    logic [31:0] load_data;

    assign win       = (req == 2'b11) ? ~last_gnt : req[1];
    assign sel_wr    = win ? wr[1]  : wr[0];
    assign sel_uns   = win ? uns[1] : uns[0];
    assign sel_size  = win ? size1  : size0;
    assign sel_addr  = win ? addr1  : addr0;
    assign sel_wdata = win ? wdata1 : wdata0;

    assign sel_err = (sel_size == SZ_ILL)
                   | ((sel_size == SZ_HALF) & sel_addr[0])
                   | ((sel_size == SZ_WORD) & (sel_addr[1:0] != 2'b00))
                   | (sel_addr[31:MEM_AW+2] != '0);

    // The aligner sees the incoming winner while idle (to register the write strobe)
    // and the latched request afterwards (to extract the returning load data).
    assign al_size = (state == ST_IDLE) ? sel_size      : lat_size;
    assign al_uns  = (state == ST_IDLE) ? sel_uns       : lat_uns;
    assign al_off  = (state == ST_IDLE) ? sel_addr[1:0] : lat_off;

    dmem_lane_align u_align (
        .size       (al_size),
        .uns        (al_uns),
        .offset     (al_off),
        .wdata      (sel_wdata),
        .mem_dout   (mem_dout),
        .lane_mask  (lane_mask),
        .store_data (store_data),
        .load_data  (load_data)
    );

    // Memory read data only becomes valid in RESP, so the load result is steered straight out.
    assign rdata = ((state == ST_RESP) && !lat_wr && !lat_err) ? load_data : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ack      <= 2'b00;
            err      <= 1'b0;
            mem_we   <= 4'b0000;
            mem_addr <= '0;
            mem_din  <= 32'h0;
            last_gnt <= 1'b1;
            gnt      <= 1'b0;
            lat_wr   <= 1'b0;
            lat_uns  <= 1'b0;
            lat_err  <= 1'b0;
            lat_size <= SZ_BYTE;
            lat_off  <= 2'b00;
        end else begin
            ack <= 2'b00;
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        gnt      <= win;
                        last_gnt <= win;
                        lat_wr   <= sel_wr;
                        lat_uns  <= sel_uns;
                        lat_err  <= sel_err;
                        lat_size <= sel_size;
                        lat_off  <= sel_addr[1:0];
                        mem_addr <= sel_addr[MEM_AW+1:2];
                        mem_din  <= store_data;
                        mem_we   <= (sel_wr && !sel_err) ? lane_mask : 4'b0000;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_we <= 4'b0000;
                    ack    <= gnt ? 2'b10 : 2'b01;
                    err    <= lat_err;
                    state  <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    mem_we <= 4'b0000;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: byte-array reference memory, per-port request queues, ack monitor.
module tb_dmem_arbiter;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        has_exp;
        logic [31:0] exp_rd;
        logic        exp_err;
    } req_t;

    logic        clk;
    logic        rst_n;
    logic        req0_b, req1_b, wr0_b, wr1_b, uns0_b, uns1_b;
    logic [1:0]  req, wr, uns;
    logic [1:0]  size0, size1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:4095];
    logic [7:0]  refmem [0:16383];

    req_t        pend0[$];
    req_t        pend1[$];
    int          exp_port[$];

    int          checks;
    int          errors;
    int          cyc;
    bit          contend;
    bit          last_ack_valid;
    int          last_ack;
    logic [3:0]  cap_we;
    logic [31:0] cap_din;

    assign req = {req1_b, req0_b};
    assign wr  = {wr1_b, wr0_b};
    assign uns = {uns1_b, uns0_b};

    dmem_arbiter #(.MEM_AW(12)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .wr       (wr),
        .size0    (size0),
        .size1    (size1),
        .uns      (uns),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .ack      (ack),
        .err      (err),
        .rdata    (rdata),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port memory with a registered read.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_we[i]) mem[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
        mem_dout <= mem[mem_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic req_t mk(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                                input logic [31:0] d, input logic he, input logic [31:0] er, input logic ee);
        req_t r;
        r.wr = w; r.size = s; r.uns = u; r.addr = a; r.wdata = d;
        r.has_exp = he; r.exp_rd = er; r.exp_err = ee;
        return r;
    endfunction

    // Reference behaviour: little-endian byte memory, applied in completion order.
    function automatic void model(input req_t r, output logic e, output logic [31:0] rd,
                                  output logic [3:0] we, output logic [31:0] din, output logic [31:0] dmask);
        int n;
        int off;
        longint v;
        longint m;
        n = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
        e = (r.size == 2'd3) || ((r.addr % n) != 0) || (r.addr >= 32'h4000);
        rd = 32'h0; we = 4'h0; din = 32'h0; dmask = 32'h0;
        if (e) return;
        off = int'(r.addr % 4);
        if (r.wr) begin
            for (int i = 0; i < n; i++) begin
                refmem[r.addr[13:0] + 14'(i)] = r.wdata[8*i +: 8];
                we[off+i] = 1'b1;
                din[8*(off+i) +: 8] = r.wdata[8*i +: 8];
                dmask[8*(off+i) +: 8] = 8'hFF;
            end
        end else begin
            v = 0;
            for (int i = 0; i < n; i++)
                v = v | (longint'(refmem[r.addr[13:0] + 14'(i)]) << (8*i));
            m = (64'sd1 <<< (8*n)) - 1;
            if (!r.uns && v[8*n-1]) v = v | ~m;
            rd = v[31:0];
        end
    endfunction

    // Monitor: pairs each ack with the oldest outstanding request of that port.
    always @(negedge clk) begin
        req_t       cur;
        logic       e;
        logic [31:0] rd, din, dmask;
        logic [3:0] we;
        int         port;
        if (!rst_n) begin
            cap_we  = 4'h0;
            cap_din = 32'h0;
        end else begin
            if (ack != 2'b00) begin
                checkOutput("ack_onehot", {31'h0, (ack == 2'b01) || (ack == 2'b10)}, 32'd1);
                port = ack[1] ? 1 : 0;
                if (exp_port.size() > 0) checkOutput("grant_order", port, exp_port.pop_front());
                if (contend && last_ack_valid) checkOutput("ack_spacing", cyc - last_ack, 3);
                last_ack_valid = contend;
                last_ack = cyc;
                if ((port == 1 && pend1.size() == 0) || (port == 0 && pend0.size() == 0)) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_ack: got ack=%b expected no ack", ack);
                end else begin
                    cur = (port == 1) ? pend1.pop_front() : pend0.pop_front();
                    model(cur, e, rd, we, din, dmask);
                    checkOutput("err", {31'h0, err}, {31'h0, e});
                    checkOutput("rdata", rdata, rd);
                    checkOutput("mem_we", {28'h0, cap_we}, {28'h0, we});
                    checkOutput("mem_din", cap_din & dmask, din);
                    if (cur.has_exp) begin
                        checkOutput("rdata_const", rdata, cur.exp_rd);
                        checkOutput("err_const", {31'h0, err}, {31'h0, cur.exp_err});
                    end
                end
                cap_we  = 4'h0;
                cap_din = 32'h0;
            end else begin
                checkOutput("idle_rdata", rdata, 32'h0);
                checkOutput("idle_err", {31'h0, err}, 32'h0);
            end
            if (mem_we != 4'h0) begin
                checkOutput("we_single_cycle", {28'h0, cap_we}, 32'h0);
                cap_we  = mem_we;
                cap_din = mem_din;
            end
        end
    end

    task automatic applyStimulus(input int p, input req_t r, input bit keep, input int lat);
        int cnt;
        bit got;
        if (p == 0) begin
            wr0_b = r.wr; size0 = r.size; uns0_b = r.uns; addr0 = r.addr; wdata0 = r.wdata;
            pend0.push_back(r); req0_b = 1'b1;
        end else begin
            wr1_b = r.wr; size1 = r.size; uns1_b = r.uns; addr1 = r.addr; wdata1 = r.wdata;
            pend1.push_back(r); req1_b = 1'b1;
        end
        cnt = 0; got = 0;
        while (!got && cnt < 30) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (ack[p]) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("[TB] FAIL ack_timeout: got no ack on port %0d expected ack within 30 cycles", p);
            if (p == 0) void'(pend0.pop_back()); else void'(pend1.pop_back());
        end else if (lat != 0) begin
            checkOutput("latency", cnt, lat);
        end
        if (!keep) begin
            if (p == 0) req0_b = 1'b0; else req1_b = 1'b0;
        end
    endtask

    task automatic randomPort(input int p, input int n);
        req_t r;
        logic [1:0] s;
        logic [31:0] a;
        int nb;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0:       a = 32'h4000 + $urandom_range(0, 255);
                1:       a = $urandom;
                default: a = $urandom_range(0, 127);
            endcase
            nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nb) - 1);
            r = mk(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, 32'h0, 1'b0);
            applyStimulus(p, r, 1'b0, 0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; contend = 0; last_ack_valid = 0; last_ack = 0;
        cap_we = 4'h0; cap_din = 32'h0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        for (int i = 0; i < 16384; i++) refmem[i] = 8'h0;
        rst_n = 1'b0;
        req0_b = 0; req1_b = 0; wr0_b = 0; wr1_b = 0; uns0_b = 0; uns1_b = 0;
        size0 = 2'd0; size1 = 2'd0; addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ack", {30'h0, ack}, 32'h0);
        checkOutput("reset_err", {31'h0, err}, 32'h0);
        checkOutput("reset_rdata", rdata, 32'h0);
        checkOutput("reset_mem_we", {28'h0, mem_we}, 32'h0);
        checkOutput("reset_mem_addr", {20'h0, mem_addr}, 32'h0);
        checkOutput("reset_mem_din", mem_din, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Both ports hammer from reset: strict alternation, port 0 first, one ack per 3 cycles.
        for (int i = 0; i < 4; i++) begin exp_port.push_back(0); exp_port.push_back(1); end
        contend = 1;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    applyStimulus(0, mk(1'b1, 2'd2, 1'b0, 32'h40 + 32'(4*i), 32'hA0A0_0000 + 32'(i), 1'b0, 0, 1'b0), i < 3, 0);
            end
            begin
                for (int i = 0; i < 4; i++)
                    applyStimulus(1, mk(1'b0, 2'd2, 1'b0, 32'h40 + 32'(4*i), 32'h0, 1'b0, 0, 1'b0), i < 3, 0);
            end
        join
        contend = 0;
        repeat (2) @(negedge clk);

        // Word store then load, exact 2-cycle latency from an idle arbiter.
        applyStimulus(0, mk(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 1'b1, 32'h0, 1'b0), 1'b0, 2);
        repeat (2) @(negedge clk);
        applyStimulus(0, mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'h12345678, 1'b0), 1'b0, 2);
        repeat (2) @(negedge clk);

        // Byte store to the top lane, then signed and unsigned byte loads.
        applyStimulus(0, mk(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, 1'b1, 32'h0, 1'b0), 1'b0, 2);
        repeat (2) @(negedge clk);
        applyStimulus(0, mk(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1, 32'hFFFFFFAB, 1'b0), 1'b0, 2);
        repeat (2) @(negedge clk);
        applyStimulus(0, mk(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1, 32'h000000AB, 1'b0), 1'b0, 2);
        repeat (2) @(negedge clk);

        // Upper-half store, then unsigned and signed half loads.
        applyStimulus(1, mk(1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, 1'b1, 32'h0, 1'b0), 1'b0, 2);
        repeat (2) @(negedge clk);
        applyStimulus(1, mk(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b1, 32'h00008001, 1'b0), 1'b0, 2);
        repeat (2) @(negedge clk);
        applyStimulus(1, mk(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b1, 32'hFFFF8001, 1'b0), 1'b0, 2);
        repeat (2) @(negedge clk);

        // Rejected requests: misaligned, illegal size, out of range.
        applyStimulus(1, mk(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 1'b1, 32'h0, 1'b1), 1'b0, 2);
        repeat (2) @(negedge clk);
        applyStimulus(1, mk(1'b1, 2'd1, 1'b0, 32'h05, 32'h0000BEEF, 1'b1, 32'h0, 1'b1), 1'b0, 2);
        repeat (2) @(negedge clk);
        applyStimulus(0, mk(1'b1, 2'd3, 1'b0, 32'h08, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1), 1'b0, 2);
        repeat (2) @(negedge clk);
        applyStimulus(0, mk(1'b1, 2'd2, 1'b0, 32'h00004000, 32'h55AA55AA, 1'b1, 32'h0, 1'b1), 1'b0, 2);
        repeat (2) @(negedge clk);
        applyStimulus(0, mk(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 1'b1, 32'h0, 1'b0), 1'b0, 2);
        repeat (2) @(negedge clk);

        // Reset while a store sits in ISSUE.
        begin
            bit seen;
            wr0_b = 1'b1; size0 = 2'd2; uns0_b = 1'b0; addr0 = 32'h30; wdata0 = 32'hDEADBEEF;
            req0_b = 1'b1;
            seen = 0;
            for (int i = 0; i < 6 && !seen; i++) begin
                @(negedge clk);
                if (mem_we != 4'h0) seen = 1;
            end
            checkOutput("rst_store_issued", {31'h0, seen}, 32'd1);
            #1 rst_n = 1'b0;
            req0_b = 1'b0;
            #1;
            checkOutput("midrst_ack", {30'h0, ack}, 32'h0);
            checkOutput("midrst_err", {31'h0, err}, 32'h0);
            checkOutput("midrst_rdata", rdata, 32'h0);
            checkOutput("midrst_mem_we", {28'h0, mem_we}, 32'h0);
            checkOutput("midrst_mem_addr", {20'h0, mem_addr}, 32'h0);
            checkOutput("midrst_mem_din", mem_din, 32'h0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end
        exp_port.push_back(0);
        exp_port.push_back(1);
        fork
            applyStimulus(0, mk(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0, 1'b0), 1'b0, 0);
            applyStimulus(1, mk(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0), 1'b0, 0);
        join
        repeat (2) @(negedge clk);

        // Randomised traffic from both ports.
        fork
            randomPort(0, 40);
            randomPort(1, 40);
        join
        repeat (4) @(negedge clk);

        checkOutput("pend0_drained", pend0.size(), 32'h0);
        checkOutput("pend1_drained", pend1.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
